// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS control path: ALU codes, opcode/funct values, mux selects, FSM states.
// S_JAL exists only when MIPS_JAL_EN is defined.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_NOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;

  localparam logic [2:0] SRCB_REG     = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_SEXT    = 3'd2;
  localparam logic [2:0] SRCB_SEXT_SH = 3'd3;
  localparam logic [2:0] SRCB_ZEXT    = 3'd4;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [3:0] S_RESET     = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_I_EXEC    = 4'd9;
  localparam logic [3:0] S_I_WB      = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
`ifdef MIPS_JAL_EN
  localparam logic [3:0] S_JAL       = 4'd13;
`endif

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct field to ALU operation code; valid is low for any funct the ALU does not implement.
module mips_alu_decoder
  import mips_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                valid
);

  always_comb begin
    alu_op = ALU_OP_W'(ALU_AND);
    valid  = 1'b1;
    case (funct)
      F_ADD:   alu_op = ALU_OP_W'(ALU_ADD);
      F_SUB:   alu_op = ALU_OP_W'(ALU_SUB);
      F_AND:   alu_op = ALU_OP_W'(ALU_AND);
      F_OR:    alu_op = ALU_OP_W'(ALU_OR);
      F_NOR:   alu_op = ALU_OP_W'(ALU_NOR);
      F_SLL:   alu_op = ALU_OP_W'(ALU_SLL);
      F_SRL:   alu_op = ALU_OP_W'(ALU_SRL);
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM driving the shared datapath strobes and selects.
// Define MIPS_JAL_EN to add the jal instruction (S_JAL); otherwise opcode 0x03 is illegal.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_a,
  output logic [2:0]          alu_src_b,
  output logic                pc_write,
  output logic [1:0]          pc_source,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                illegal_instr
);

  logic [3:0]          state, next_state;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic                r_valid;

  mips_alu_decoder #(.ALU_OP_W(ALU_OP_W)) u_alu_dec (
    .funct  (funct),
    .alu_op (r_alu_op),
    .valid  (r_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RESET;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:     next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                        next_state = S_R_EXEC;
          OP_LW, OP_SW:                    next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                  next_state = S_BRANCH;
          OP_J:                            next_state = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state = S_I_EXEC;
`ifdef MIPS_JAL_EN
          OP_JAL:                          next_state = S_JAL;
`endif
          default:                         next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    next_state = r_valid ? S_R_WB : S_FETCH;
      S_I_EXEC:    next_state = S_I_WB;
      default:     next_state = S_FETCH;
    endcase
  end

  // Decode falling straight back to fetch is exactly the unsupported-opcode case.
  always_comb begin
    alu_op        = ALU_OP_W'(ALU_AND);
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_write      = 1'b0;
    pc_source     = PCSRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = REGDST_RT;
    mem_to_reg    = M2R_ALUOUT;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        alu_op    = ALU_OP_W'(ALU_ADD);
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_op        = ALU_OP_W'(ALU_ADD);
        alu_src_b     = SRCB_SEXT_SH;
        illegal_instr = (next_state == S_FETCH);
      end
      S_MEM_ADDR: begin
        alu_op    = ALU_OP_W'(ALU_ADD);
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_op        = r_alu_op;
        alu_src_a     = 1'b1;
        illegal_instr = !r_valid;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RD;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_ZEXT;
        case (opcode)
          OP_ANDI: alu_op = ALU_OP_W'(ALU_AND);
          OP_ORI:  alu_op = ALU_OP_W'(ALU_OR);
          OP_LUI:  alu_op = ALU_OP_W'(ALU_LUI);
          default: begin
            alu_op    = ALU_OP_W'(ALU_ADD);
            alu_src_b = SRCB_SEXT;
          end
        endcase
      end
      S_I_WB:      reg_write = 1'b1;
      S_BRANCH: begin
        alu_op    = ALU_OP_W'(ALU_SUB);
        alu_src_a = 1'b1;
        pc_source = PCSRC_ALUOUT;
        pc_write  = (opcode == OP_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
`ifdef MIPS_JAL_EN
      S_JAL: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RA;
        mem_to_reg = M2R_PC;
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Table-driven, scoreboarded bench for mips_multicycle_control (default build, jal disabled).
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic [3:0] alu_op;
  logic       alu_src_a, pc_write, iord, mem_read, mem_write, ir_write, reg_write, illegal_instr;
  logic [2:0] alu_src_b;
  logic [1:0] pc_source, reg_dst, mem_to_reg;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    outs_t      exp;
    logic       chk_alu;
    string      name;
  } vec_t;

  typedef struct {
    outs_t exp;
    logic  chk_alu;
    string name;
  } sb_t;

  vec_t  vecs[$];
  sb_t   sb_q[$];
  outs_t act;
  int    n_checks = 0;
  int    n_fail = 0;

  mips_multicycle_control #(.ALU_OP_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_write      (pc_write),
    .pc_source     (pc_source),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  assign act = {alu_op, alu_src_a, alu_src_b, pc_write, pc_source, iord, mem_read,
                mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_instr};

  // Expected output bundles per state, written from the datapath contract.
  function automatic outs_t o_zero();
    return '0;
  endfunction

  function automatic outs_t o_fetch(logic rdy);
    outs_t o = '0;
    o.mem_read = 1'b1; o.alu_op = 4'd3; o.alu_src_b = 3'd1;
    o.ir_write = rdy;  o.pc_write = rdy;
    return o;
  endfunction

  function automatic outs_t o_decode(logic ill);
    outs_t o = '0;
    o.alu_op = 4'd3; o.alu_src_b = 3'd3; o.illegal = ill;
    return o;
  endfunction

  function automatic outs_t o_alu(logic [3:0] op, logic [2:0] srcb, logic ill);
    outs_t o = '0;
    o.alu_op = op; o.alu_src_a = 1'b1; o.alu_src_b = srcb; o.illegal = ill;
    return o;
  endfunction

  function automatic outs_t o_wb(logic [1:0] dst, logic [1:0] m2r);
    outs_t o = '0;
    o.reg_write = 1'b1; o.reg_dst = dst; o.mem_to_reg = m2r;
    return o;
  endfunction

  function automatic outs_t o_mem(logic rd);
    outs_t o = '0;
    o.mem_read = rd; o.mem_write = !rd; o.iord = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_branch(logic pw);
    outs_t o = '0;
    o.alu_op = 4'd4; o.alu_src_a = 1'b1; o.pc_source = 2'd1; o.pc_write = pw;
    return o;
  endfunction

  function automatic outs_t o_jump();
    outs_t o = '0;
    o.pc_write = 1'b1; o.pc_source = 2'd2;
    return o;
  endfunction

  task automatic row(logic r, logic [5:0] op, logic [5:0] fn, logic z, logic rdy,
                     outs_t e, string name, logic ca = 1'b1);
    vecs.push_back('{r, op, fn, z, rdy, e, ca, name});
  endtask

  task automatic checkOutput(string name, outs_t got, outs_t want, logic ca);
    outs_t g = got;
    outs_t w = want;
    if (!ca) begin
      g.alu_op = '0;
      w.alu_op = '0;
    end
    n_checks++;
    if (g !== w)
      begin
        n_fail++;
        $display("[TB] FAIL %s: got %h required %h", name, got, want);
      end
  endtask

  task automatic applyStimulus(vec_t v);
    @(posedge clk);
    #1;
    reset     = v.rst_n;
    opcode    = v.op;
    funct     = v.fn;
    zero      = v.z;
    mem_ready = v.rdy;
    sb_q.push_back('{v.exp, v.chk_alu, v.name});
  endtask

  always @(negedge clk) begin
    sb_t s;
    if (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      checkOutput(s.name, act, s.exp, s.chk_alu);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] rfn[7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02};
    logic [3:0] rop[7] = '{4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd6, 4'd7};
    logic [5:0] iop[4] = '{6'h08, 6'h0C, 6'h0D, 6'h0F};
    logic [3:0] ialu[4] = '{4'd3, 4'd0, 4'd1, 4'd5};
    logic [2:0] isrc[4] = '{3'd2, 3'd4, 3'd4, 3'd4};

    for (int i = 0; i < 3; i++) row(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, o_zero(), "reset_hold");
    row(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, o_zero(), "reset_release");

    for (int i = 0; i < 7; i++) begin
      row(1'b1, 6'h00, rfn[i], 1'b0, 1'b1, o_fetch(1'b1), $sformatf("r%0d_fetch", i));
      row(1'b1, 6'h00, rfn[i], 1'b0, 1'b1, o_decode(1'b0), $sformatf("r%0d_decode", i));
      row(1'b1, 6'h00, rfn[i], 1'b0, 1'b1, o_alu(rop[i], 3'd0, 1'b0), $sformatf("r%0d_exec", i));
      row(1'b1, 6'h00, rfn[i], 1'b0, 1'b1, o_wb(2'd1, 2'd0), $sformatf("r%0d_wb", i));
    end

    row(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, o_fetch(1'b0), "lw_fetch_wait");
    row(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, o_fetch(1'b1), "lw_fetch");
    row(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, o_decode(1'b0), "lw_decode");
    row(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, o_alu(4'd3, 3'd2, 1'b0), "lw_addr");
    row(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, o_mem(1'b1), "lw_read_wait1");
    row(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, o_mem(1'b1), "lw_read_wait2");
    row(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, o_mem(1'b1), "lw_read");
    row(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, o_wb(2'd0, 2'd1), "lw_wb");

    row(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, o_fetch(1'b1), "sw_fetch");
    row(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, o_decode(1'b0), "sw_decode");
    row(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, o_alu(4'd3, 3'd2, 1'b0), "sw_addr");
    row(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, o_mem(1'b0), "sw_write_wait");
    row(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, o_mem(1'b0), "sw_write");

    for (int i = 0; i < 4; i++) begin
      logic [5:0] bop;
      logic       bz;
      bop = (i < 2) ? 6'h04 : 6'h05;
      bz  = (i % 2 == 0);
      row(1'b1, bop, 6'h00, bz, 1'b1, o_fetch(1'b1), $sformatf("br%0d_fetch", i));
      row(1'b1, bop, 6'h00, bz, 1'b1, o_decode(1'b0), $sformatf("br%0d_decode", i));
      row(1'b1, bop, 6'h00, bz, 1'b1, o_branch((bop == 6'h05) ? !bz : bz), $sformatf("br%0d_branch", i));
    end

    row(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, o_fetch(1'b1), "j_fetch");
    row(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, o_decode(1'b0), "j_decode");
    row(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, o_jump(), "j_jump");

    for (int i = 0; i < 4; i++) begin
      row(1'b1, iop[i], 6'h00, 1'b0, 1'b1, o_fetch(1'b1), $sformatf("i%0d_fetch", i));
      row(1'b1, iop[i], 6'h00, 1'b0, 1'b1, o_decode(1'b0), $sformatf("i%0d_decode", i));
      row(1'b1, iop[i], 6'h00, 1'b0, 1'b1, o_alu(ialu[i], isrc[i], 1'b0), $sformatf("i%0d_exec", i));
      row(1'b1, iop[i], 6'h00, 1'b0, 1'b1, o_wb(2'd0, 2'd0), $sformatf("i%0d_wb", i));
    end

    row(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, o_fetch(1'b1), "bad_op_fetch");
    row(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, o_decode(1'b1), "bad_op_decode");
    row(1'b1, 6'h00, 6'h3A, 1'b0, 1'b1, o_fetch(1'b1), "bad_fn_fetch");
    row(1'b1, 6'h00, 6'h3A, 1'b0, 1'b1, o_decode(1'b0), "bad_fn_decode");
    row(1'b1, 6'h00, 6'h3A, 1'b0, 1'b1, o_alu(4'd0, 3'd0, 1'b1), "bad_fn_exec", 1'b0);
    row(1'b1, 6'h03, 6'h00, 1'b0, 1'b1, o_fetch(1'b1), "jal_fetch");
    row(1'b1, 6'h03, 6'h00, 1'b0, 1'b1, o_decode(1'b1), "jal_off_decode");
    row(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, o_fetch(1'b0), "final_fetch");

    foreach (vecs[i]) applyStimulus(vecs[i]);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL sb_drain: got %0d pending required 0", sb_q.size());
    end

    // Asynchronous reset landing in the middle of a stalled store.
    @(negedge clk);
    reset = 1'b0; opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("hs_fetch", act, o_fetch(1'b1), 1'b1);
    @(posedge clk); #1;
    checkOutput("hs_decode", act, o_decode(1'b0), 1'b1);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checkOutput("hs_addr", act, o_alu(4'd3, 3'd2, 1'b0), 1'b1);
    @(posedge clk); #1;
    checkOutput("hs_write", act, o_mem(1'b0), 1'b1);
    @(posedge clk); #1;
    checkOutput("hs_write_wait", act, o_mem(1'b0), 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("hs_async_reset", act, o_zero(), 1'b1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("hs_reset_hold", act, o_zero(), 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("hs_refetch", act, o_fetch(1'b1), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
